mmio_uart_tx: RTL and testbench

// - Memory-mapped UART transmitter; responder on the core's data-memory bus (same we/a/wd/rd signalling as dmem).
// - Core stores bytes to TXDATA; block buffers them in a FIFO and serialises 8N1 LSB-first on tx.
// - Top-level decodes BASE_ADDR window: hit=1 routes rd to this block and gates dmem_Write away from dmem.

---
 rtl/mmio_uart_tx.sv | 242 ++++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter on the data-memory bus.
// Bytes written to TXDATA are queued in a TX FIFO and sent LSB-first, 8N1, on tx.
// Register window (a[3:2]): 0 TXDATA(W), 1 STATUS(R/W1C OVF), 2 BAUDDIV(RW), 3 reserved.
// Build option: define MMIO_UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (frame becomes 11 bit periods).
`timescale 1ns/1ps

module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        tx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

`ifdef MMIO_UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          ovf_q, ovf_d;
    logic          tx_q, tx_d;
`ifdef MMIO_UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic [1:0]    reg_sel;
    logic          wr_txdata, wr_status, wr_div;
    logic          fifo_empty, fifo_full;
    logic          push, drop, pop;
    logic          bit_end, busy;
    logic [7:0]    head;
    logic [15:0]   period_m1;
    logic [31:0]   status;
    logic          unused_bits;

    // Address decode and write qualification
    assign hit       = (a[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = a[3:2];
    assign wr_txdata = hit & we & (reg_sel == 2'd0);
    assign wr_status = hit & we & (reg_sel == 2'd1);
    assign wr_div    = hit & we & (reg_sel == 2'd2);

    // FIFO flags: equal index with differing wrap bit means full
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push       = wr_txdata & ~fifo_full;
    assign drop       = wr_txdata & fifo_full;
    assign head       = mem_q[rptr_q[AW-1:0]];

    // A divider of 0 behaves as 1 clock per bit
    assign period_m1 = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);
    assign bit_end   = (cnt_q == 16'd0);
    assign busy      = (state_q != S_IDLE);
    assign status    = {27'd0, PAR_EN, ovf_q, busy, fifo_empty, fifo_full};
    assign tx        = tx_q;

    assign unused_bits = ^{a[1:0], wd[31:16]};

    // Combinational read mux; zero whenever the window is not hit
    always_comb begin
        rd = 32'd0;
        if (hit) begin
            case (reg_sel)
                2'd1:    rd = status;
                2'd2:    rd = {16'd0, div_q};
                default: rd = 32'd0;
            endcase
        end
    end

    // Register-file next state: pointers, divider, sticky overflow
    always_comb begin
        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop);
        div_d  = div_q;
        ovf_d  = ovf_q;
        if (wr_div) begin
            div_d = wd[15:0];
        end
        if (wr_status && wd[3]) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Transmit FSM next state, bit timer, shifter and next tx level
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    cnt_d   = period_m1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    cnt_d   = period_m1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    cnt_d   = period_m1;
                    if (bit_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = period_m1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                        cnt_d   = period_m1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pop) begin
            shift_d = head;
`ifdef MMIO_UART_TX_PARITY_EN
            par_d   = ^head;
`endif
        end

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef MMIO_UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO storage; entries are not reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= wd[7:0];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            div_q   <= DEFAULT_DIV;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            ovf_q   <= 1'b0;
            tx_q    <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
            tx_q    <= tx_d;
`ifdef MMIO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx.
`timescale 1ns/1ps

module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_ST  = BASE + 32'd4;
    localparam logic [31:0] A_DIV = BASE + 32'd8;
    localparam logic [31:0] A_RSV = BASE + 32'd12;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int          NB = 11;
    localparam logic [31:0] PB = 32'h10;
`else
    localparam int          NB = 10;
    localparam logic [31:0] PB = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic [31:0] a   = 32'd0;
    logic [31:0] wd  = 32'd0;
    logic [31:0] rd;
    logic        hit;
    logic        tx;

    int checks = 0;
    int errors = 0;

    mmio_uart_tx dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .a   (a),
        .wd  (wd),
        .rd  (rd),
        .hit (hit),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected line level for bit slot idx of a frame carrying b
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[3'(idx - 1)];
        if (NB == 11 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        we = 1'b1; a = addr; wd = data;
        @(negedge clk);
        we = 1'b0; a = 32'd0; wd = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        we = 1'b0; a = addr;
        #1;
        data = rd;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        a = 32'd0; #1;
        checks++; if (hit !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL reset_nohit: hit=%b rd=%0h expected hit=0 rd=0", hit, rd); end
        bus_read(A_ST, v);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL reset_hit: got %b expected 1", hit); end
        checks++; if (v !== (32'h2 | PB)) begin errors++; $display("FAIL reset_status: got %0h expected %0h", v, 32'h2 | PB); end
        bus_read(A_DIV, v);
        checks++; if (v !== 32'd234) begin errors++; $display("FAIL reset_div: got %0d expected 234", v); end
        bus_read(A_TX, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_txdata_read: got %0h expected 0", v); end
    endtask

    task automatic test_frame();
        logic [31:0] v;
        bus_write(A_DIV, 32'd4);
        bus_write(A_TX, 32'h55);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL frame_latency_tx: got %b expected 1", tx); end
        bus_read(A_ST, v);
        checks++; if (v !== PB) begin errors++; $display("FAIL frame_queued_status: got %0h expected %0h", v, PB); end
        for (int k = 0; k < NB * 4; k++) begin
            @(negedge clk);
            checks++; if (tx !== exp_bit(8'h55, k / 4)) begin errors++; $display("FAIL frame_tx k=%0d: got %b expected %b", k, tx, exp_bit(8'h55, k / 4)); end
            bus_read(A_ST, v);
            checks++; if (v[2] !== 1'b1) begin errors++; $display("FAIL frame_busy k=%0d: got %b expected 1", k, v[2]); end
        end
        @(negedge clk);
        bus_read(A_ST, v);
        checks++; if (tx !== 1'b1 || v !== (32'h2 | PB)) begin errors++; $display("FAIL frame_end: tx=%b status=%0h expected tx=1 status=%0h", tx, v, 32'h2 | PB); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        bus_write(A_DIV, 32'd2);
        @(negedge clk);
        we = 1'b1; a = A_TX; wd = 32'hA5;
        @(negedge clk);
        wd = 32'h3C;
        @(negedge clk);
        we = 1'b0; a = 32'd0; wd = 32'd0;
        for (int k = 0; k < 2 * NB * 2; k++) begin
            if (k > 0) @(negedge clk);
            b = (k < NB * 2) ? 8'hA5 : 8'h3C;
            checks++; if (tx !== exp_bit(b, (k % (NB * 2)) / 2)) begin errors++; $display("FAIL b2b_tx k=%0d: got %b expected %b", k, tx, exp_bit(b, (k % (NB * 2)) / 2)); end
        end
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b expected 1", tx); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        bus_write(A_DIV, 32'd1000);
        for (int i = 0; i < 9; i++) bus_write(A_TX, 32'(i + 1));
        bus_read(A_ST, v);
        checks++; if (v !== (32'h5 | PB)) begin errors++; $display("FAIL ovf_full: got %0h expected %0h", v, 32'h5 | PB); end
        bus_write(A_TX, 32'hAA);
        bus_read(A_ST, v);
        checks++; if (v !== (32'hD | PB)) begin errors++; $display("FAIL ovf_set: got %0h expected %0h", v, 32'hD | PB); end
        bus_write(A_ST, 32'h7);
        bus_read(A_ST, v);
        checks++; if (v !== (32'hD | PB)) begin errors++; $display("FAIL ovf_noclear: got %0h expected %0h", v, 32'hD | PB); end
        bus_write(A_ST, 32'h8);
        bus_read(A_ST, v);
        checks++; if (v !== (32'h5 | PB)) begin errors++; $display("FAIL ovf_clear: got %0h expected %0h", v, 32'h5 | PB); end
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL ovf_startbit: got %b expected 0", tx); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_read(A_ST, v);
        checks++; if (v !== (32'h2 | PB) || tx !== 1'b1) begin errors++; $display("FAIL ovf_flush: status=%0h tx=%b expected status=%0h tx=1", v, tx, 32'h2 | PB); end
    endtask

    task automatic test_bauddiv();
        logic [31:0] v;
        bus_write(A_DIV, 32'd0);
        bus_read(A_DIV, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL div_zero_read: got %0d expected 0", v); end
        bus_write(A_TX, 32'h81);
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            checks++; if (tx !== exp_bit(8'h81, k)) begin errors++; $display("FAIL div_zero_tx k=%0d: got %b expected %b", k, tx, exp_bit(8'h81, k)); end
        end
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL div_zero_idle: got %b expected 1", tx); end
        bus_write(A_DIV, 32'h0001_2345);
        bus_read(A_DIV, v);
        checks++; if (v !== 32'h2345) begin errors++; $display("FAIL div_width: got %0h expected 2345", v); end
        bus_write(A_RSV, 32'hFFFF_FFFF);
        bus_read(A_RSV, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL rsv_read: got %0h expected 0", v); end
        bus_read(A_ST, v);
        checks++; if (v !== (32'h2 | PB)) begin errors++; $display("FAIL rsv_status: got %0h expected %0h", v, 32'h2 | PB); end
        bus_write(BASE + 32'd24, 32'd7);
        bus_read(A_DIV, v);
        checks++; if (v !== 32'h2345) begin errors++; $display("FAIL miss_write: got %0h expected 2345", v); end
        a = BASE + 32'd16; #1;
        checks++; if (hit !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL miss_above: hit=%b rd=%0h expected hit=0 rd=0", hit, rd); end
        a = BASE - 32'd4; #1;
        checks++; if (hit !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL miss_below: hit=%b rd=%0h expected hit=0 rd=0", hit, rd); end
    endtask

    task automatic test_div_midframe();
        int idx;
        logic [31:0] v;
        bus_write(A_DIV, 32'd4);
        bus_write(A_TX, 32'hF0);
        @(negedge clk);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_start0: got %b expected 0", tx); end
        we = 1'b1; a = A_DIV; wd = 32'd2;
        @(negedge clk);
        we = 1'b0; a = 32'd0; wd = 32'd0;
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_start1: got %b expected 0", tx); end
        for (int k = 2; k < 4 + (NB - 1) * 2; k++) begin
            @(negedge clk);
            idx = (k < 4) ? 0 : 1 + (k - 4) / 2;
            checks++; if (tx !== exp_bit(8'hF0, idx)) begin errors++; $display("FAIL mid_tx k=%0d: got %b expected %b", k, tx, exp_bit(8'hF0, idx)); end
        end
        @(negedge clk);
        bus_read(A_ST, v);
        checks++; if (tx !== 1'b1 || v !== (32'h2 | PB)) begin errors++; $display("FAIL mid_end: tx=%b status=%0h expected tx=1 status=%0h", tx, v, 32'h2 | PB); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] v;
        bus_write(A_DIV, 32'd4);
        bus_write(A_TX, 32'h55);
        bus_write(A_TX, 32'h66);
        repeat (16) @(negedge clk);
        checks++; if (tx !== exp_bit(8'h55, 4)) begin errors++; $display("FAIL rstmid_bit3: got %b expected %b", tx, exp_bit(8'h55, 4)); end
        bus_read(A_ST, v);
        checks++; if (v !== (32'h4 | PB)) begin errors++; $display("FAIL rstmid_pre_status: got %0h expected %0h", v, 32'h4 | PB); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
        bus_read(A_ST, v);
        checks++; if (v !== (32'h2 | PB)) begin errors++; $display("FAIL rstmid_status: got %0h expected %0h", v, 32'h2 | PB); end
        bus_read(A_DIV, v);
        checks++; if (v !== 32'd234) begin errors++; $display("FAIL rstmid_div: got %0d expected 234", v); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_quiet k=%0d: got %b expected 1", k, tx); end
        end
    endtask

`ifdef MMIO_UART_TX_PARITY_EN
    task automatic test_parity();
        logic [31:0] v;
        bus_write(A_DIV, 32'd2);
        bus_write(A_TX, 32'h07);
        for (int k = 0; k < NB * 2; k++) begin
            @(negedge clk);
            checks++; if (tx !== exp_bit(8'h07, k / 2)) begin errors++; $display("FAIL parity_tx k=%0d: got %b expected %b", k, tx, exp_bit(8'h07, k / 2)); end
        end
        bus_read(A_ST, v);
        checks++; if (v[4] !== 1'b1) begin errors++; $display("FAIL parity_flag: got %b expected 1", v[4]); end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_overflow();
        test_bauddiv();
        test_div_midframe();
        test_reset_midframe();
`ifdef MMIO_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
